// File: rtl/rm14_decode.sv
// RM(1,4) maximum-likelihood decoder: 4-stage serial FHT, then peak search.
// Define RM14_DEC_FAST_SEARCH_EN for a single-cycle 16-way argmax search.
module rm14_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] codeword,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  message,
    output logic [3:0]  nerr,
    output logic        uncorrectable
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FHT,
        S_SEARCH,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [5:0] r_f   [16];
    logic signed [5:0] w_fht [16];
    logic [3:0]        r_cnt;
    logic [3:0]        w_step;

    logic [4:0] w_res_mag;
    logic [3:0] w_res_idx;
    logic       w_res_neg;
    logic [4:0] w_nerr_full;
    logic       w_last;

    logic [4:0] r_msg;
    logic [3:0] r_nerr;
    logic       r_unc;

    function automatic logic [4:0] mag6(input logic signed [5:0] v);
        logic signed [5:0] a;
        a = v[5] ? -v : v;
        return a[4:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid)         w_next = S_FHT;
            S_FHT:    if (r_cnt == 4'd3)    w_next = S_SEARCH;
            S_SEARCH: if (w_last)           w_next = S_DONE;
            S_DONE:   if (out_ready)        w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // Butterfly for stage r_cnt: pairs (j, j+2^s) with bit s of j clear.
    assign w_step = 4'd1 << r_cnt[1:0];

    always_comb begin
        w_fht = r_f;
        for (int j = 0; j < 16; j++) begin
            if ((4'(j) & w_step) == 4'd0) begin
                w_fht[j] = r_f[j] + r_f[4'(j) | w_step];
            end else begin
                w_fht[j] = r_f[4'(j) & ~w_step] - r_f[j];
            end
        end
    end

`ifdef RM14_DEC_FAST_SEARCH_EN
    // Strictly-greater compare in ascending order: lowest index wins ties.
    always_comb begin
        w_res_mag = '0;
        w_res_idx = '0;
        w_res_neg = 1'b0;
        for (int u = 0; u < 16; u++) begin
            if (mag6(r_f[u]) > w_res_mag) begin
                w_res_mag = mag6(r_f[u]);
                w_res_idx = 4'(u);
                w_res_neg = r_f[u][5];
            end
        end
    end

    assign w_last = 1'b1;
`else
    logic [4:0] r_best_mag;
    logic [3:0] r_best_idx;
    logic       r_best_neg;
    logic [4:0] w_cur_mag;

    assign w_cur_mag = mag6(r_f[r_cnt]);

    always_comb begin
        w_res_mag = r_best_mag;
        w_res_idx = r_best_idx;
        w_res_neg = r_best_neg;
        if (w_cur_mag > r_best_mag) begin
            w_res_mag = w_cur_mag;
            w_res_idx = r_cnt;
            w_res_neg = r_f[r_cnt][5];
        end
    end

    assign w_last = (r_cnt == 4'd15);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_best_mag <= '0;
            r_best_idx <= '0;
            r_best_neg <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_best_mag <= '0;
            r_best_idx <= '0;
            r_best_neg <= 1'b0;
        end else if (r_state == S_SEARCH) begin
            r_best_mag <= w_res_mag;
            r_best_idx <= w_res_idx;
            r_best_neg <= w_res_neg;
        end
    end
`endif

    assign w_nerr_full = (5'd16 - w_res_mag) >> 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < 16; j++) begin
                r_f[j] <= '0;
            end
            r_cnt  <= '0;
            r_msg  <= '0;
            r_nerr <= '0;
            r_unc  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int j = 0; j < 16; j++) begin
                            r_f[j] <= codeword[j] ? -6'sd1 : 6'sd1;
                        end
                        r_cnt <= '0;
                    end
                end
                S_FHT: begin
                    r_f   <= w_fht;
                    r_cnt <= (r_cnt == 4'd3) ? 4'd0 : r_cnt + 4'd1;
                end
                S_SEARCH: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_msg  <= {w_res_idx, w_res_neg};
                        r_nerr <= w_nerr_full[3:0];
                        r_unc  <= (w_res_mag <= 5'd8);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign message       = r_msg;
    assign nerr          = r_nerr;
    assign uncorrectable = r_unc;

endmodule

// File: tb/tb_rm14_decode.sv
// Self-checking bench for rm14_decode: direct-correlation reference model,
// directed cases, backpressure, mid-search reset, exhaustive single-error sweep.
module tb_rm14_decode;

`ifdef RM14_DEC_FAST_SEARCH_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 20;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] codeword;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  message;
    logic [3:0]  nerr;
    logic        uncorrectable;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_msg;
    logic [3:0] exp_nerr;
    logic       exp_unc;

    rm14_decode dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .codeword      (codeword),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .message       (message),
        .nerr          (nerr),
        .uncorrectable (uncorrectable)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic logic [15:0] enc(input logic [4:0] m);
        logic [15:0] c;
        logic [3:0]  jj;
        for (int j = 0; j < 16; j++) begin
            jj   = 4'(j);
            c[j] = m[0] ^ (^(m[4:1] & jj));
        end
        return c;
    endfunction

    // Correlate against every affine codeword directly; strict > keeps lowest u.
    task automatic model(input logic [15:0] w, output logic [4:0] m,
                         output logic [3:0] ne, output logic un);
        int best_mag;
        int best_v;
        int best_u;
        int v;
        int mag;
        logic [3:0] uu;
        logic [3:0] jj;
        best_mag = -1;
        best_v   = 0;
        best_u   = 0;
        for (int u = 0; u < 16; u++) begin
            uu = 4'(u);
            v  = 0;
            for (int j = 0; j < 16; j++) begin
                jj = 4'(j);
                v += (w[j] ^ (^(uu & jj))) ? -1 : 1;
            end
            mag = (v < 0) ? -v : v;
            if (mag > best_mag) begin
                best_mag = mag;
                best_v   = v;
                best_u   = u;
            end
        end
        m  = {4'(best_u), (best_v < 0) ? 1'b1 : 1'b0};
        ne = 4'((16 - best_mag) / 2);
        un = (best_mag <= 8);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            check("mon_message", message, exp_msg);
            check("mon_nerr", nerr, exp_nerr);
            check("mon_uncorr", uncorrectable, exp_unc);
            check("mon_in_ready_busy", in_ready, 0);
        end
    end

    task automatic run(input logic [15:0] w, input int hold, input bit pulse,
                       output logic [4:0] gm, output logic [3:0] gn,
                       output logic gu);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("idle_wait", in_ready, 1);
        model(w, exp_msg, exp_nerr, exp_unc);
        in_valid = 1'b1;
        codeword = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        codeword = 16'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, LAT);
        gm = message;
        gn = nerr;
        gu = uncorrectable;
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == hold / 2) begin
                in_valid = 1'b1;
                codeword = 16'($urandom);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        if (hold > 0) begin
            check("hold_message", message, gm);
            check("hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        if (pulse) begin
            repeat (3) @(posedge clk);
            #1;
            check("pulse_not_captured", in_ready, 1);
        end
    endtask

    initial begin
        logic [4:0]  gm;
        logic [3:0]  gn;
        logic        gu;
        logic [15:0] w;
        logic [4:0]  m;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        codeword  = '0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_message", message, 0);
        check("rst_nerr", nerr, 0);
        check("rst_uncorr", uncorrectable, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run(16'h0000, 0, 1'b0, gm, gn, gu);
        check("zero_msg", gm, 5'b00000);
        check("zero_nerr", gn, 0);
        check("zero_unc", gu, 0);

        run(16'hAA55, 0, 1'b0, gm, gn, gu);
        check("clean_msg", gm, 5'b10011);
        check("clean_nerr", gn, 0);
        check("clean_unc", gu, 0);

        run(16'hAE74, 0, 1'b0, gm, gn, gu);
        check("err3_msg", gm, 5'b10011);
        check("err3_nerr", gn, 3);
        check("err3_unc", gu, 0);

        run(16'h000F, 10, 1'b1, gm, gn, gu);
        check("tie_msg", gm, 5'b00000);
        check("tie_nerr", gn, 4);
        check("tie_unc", gu, 1);

        // Abort a word mid-search, then decode again from clean state.
        @(negedge clk);
        in_valid = 1'b1;
        codeword = 16'h1234;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (LAT == 20 ? 8 : 4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_message", message, 0);
        check("midrst_nerr", nerr, 0);
        @(negedge clk);
        reset = 1'b0;
        run(16'hAE74, 0, 1'b0, gm, gn, gu);
        check("postrst_msg", gm, 5'b10011);
        check("postrst_nerr", gn, 3);

        for (int k = 0; k < 32; k++) begin
            m = 5'(k);
            for (int b = 0; b < 16; b++) begin
                w = enc(m) ^ (16'd1 << b);
                run(w, 0, 1'b0, gm, gn, gu);
                check("sweep_msg", gm, m);
                check("sweep_nerr", gn, 1);
            end
        end

        for (int k = 0; k < 150; k++) begin
            if (k[0]) begin
                w = 16'($urandom);
            end else begin
                w = enc(5'($urandom));
                for (int e = 0; e < int'($urandom_range(0, 5)); e++) begin
                    w = w ^ (16'd1 << $urandom_range(0, 15));
                end
            end
            run(w, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                gm, gn, gu);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
